// File: rtl/rf_wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  // Writeback port indices; also used as the round-robin favoured-port value.
  typedef enum logic {
    WB_PORT_ALU  = 1'b0,
    WB_PORT_LOAD = 1'b1
  } wb_port_e;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_X0;
  endfunction

endpackage

// File: rtl/rf_wb_arb_if.sv
// Writeback request/grant bundle between the two requesters, the arbiter
// and the register-file write port.
interface rf_wb_arb_if;
  import rf_wb_pkg::*;

  logic                  i_p0_valid;
  logic                  o_p0_ready;
  logic [REG_ADDR_W-1:0] i_p0_waddr;
  logic [XLEN-1:0]       i_p0_wdata;
  logic                  i_p1_valid;
  logic                  o_p1_ready;
  logic [REG_ADDR_W-1:0] i_p1_waddr;
  logic [XLEN-1:0]       i_p1_wdata;
  logic                  o_rd_wen;
  logic [REG_ADDR_W-1:0] o_rd_waddr;
  logic [XLEN-1:0]       o_rd_wdata;
  logic                  o_p1_starved;

  // Requester / register-file side.
  modport master (
    output i_p0_valid, i_p0_waddr, i_p0_wdata,
    output i_p1_valid, i_p1_waddr, i_p1_wdata,
    input  o_p0_ready, o_p1_ready,
    input  o_rd_wen, o_rd_waddr, o_rd_wdata, o_p1_starved
  );

  // Arbiter side.
  modport slave (
    input  i_p0_valid, i_p0_waddr, i_p0_wdata,
    input  i_p1_valid, i_p1_waddr, i_p1_wdata,
    output o_p0_ready, o_p1_ready,
    output o_rd_wen, o_rd_waddr, o_rd_wdata, o_p1_starved
  );

endinterface

// File: rtl/rf_wb_arb_pick.sv
// Combinational two-way grant selection. x0 requests never compete.
module rf_wb_arb_pick (
  input  logic [1:0] valid_i,
  input  logic [1:0] x0_i,
  input  logic       prio_p1_i,
  output logic [1:0] gnt_o
);

  logic [1:0] live;

  assign live = valid_i & ~x0_i;

  // Port 1 wins when it is alone or holds priority; otherwise port 0.
  always_comb begin
    gnt_o = '0;
    if (live[1] && (prio_p1_i || !live[0])) begin
      gnt_o[1] = 1'b1;
    end else if (live[0]) begin
      gnt_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: two valid/ready requesters share one
// registered write port. Fixed priority with port-1 starvation forcing by
// default; define RF_WB_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module rf_wb_arb
  import rf_wb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  rf_wb_arb_if.slave  wb
);

  logic [1:0]            valid;
  logic [1:0]            x0;
  logic [1:0]            gnt;
  logic                  prio_p1;
  logic                  starved;
  logic                  rd_wen_q;
  logic [REG_ADDR_W-1:0] rd_waddr_q;
  logic [XLEN-1:0]       rd_wdata_q;

  assign valid = {wb.i_p1_valid, wb.i_p0_valid};
  assign x0    = {is_x0(wb.i_p1_waddr), is_x0(wb.i_p0_waddr)};

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
  // fav_q names the port that wins the next contention; resetting it to
  // port 0 makes the first contended grant go to port 0, after which it
  // always points at the port that did not win most recently.
  wb_port_e fav_q, fav_d;

  // Move favour away from whichever port took a real (non-x0) grant.
  always_comb begin
    fav_d = fav_q;
    if (gnt[WB_PORT_ALU]) begin
      fav_d = WB_PORT_LOAD;
    end else if (gnt[WB_PORT_LOAD]) begin
      fav_d = WB_PORT_ALU;
    end
  end

  // Favoured-port register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fav_q <= WB_PORT_ALU;
    end else begin
      fav_q <= fav_d;
    end
  end

  assign prio_p1 = (fav_q == WB_PORT_LOAD);
  assign starved = 1'b0;
`else
  localparam int unsigned     CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A valid, non-x0 port 1 that is not granted has necessarily lost to
  // port 0; an x0 port-1 request leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt[1] || !valid[1]) begin
      cnt_d = '0;
    end else if (!x0[1] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (STARVE_MAX != 0) && (cnt_q == CNT_MAX);
  assign prio_p1 = starved;
`endif

  rf_wb_arb_pick u_pick (
    .valid_i   (valid),
    .x0_i      (x0),
    .prio_p1_i (prio_p1),
    .gnt_o     (gnt)
  );

  // Ready: x0 requests are absorbed immediately, others only when granted.
  always_comb begin
    wb.o_p0_ready = 1'b0;
    wb.o_p1_ready = 1'b0;
    if (!i_rst) begin
      wb.o_p0_ready = valid[0] && (x0[0] || gnt[0]);
      wb.o_p1_ready = valid[1] && (x0[1] || gnt[1]);
    end
  end

  // Register the winning write; address/data hold when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_wen_q   <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
    end else if (gnt[1]) begin
      rd_wen_q   <= 1'b1;
      rd_waddr_q <= wb.i_p1_waddr;
      rd_wdata_q <= wb.i_p1_wdata;
    end else if (gnt[0]) begin
      rd_wen_q   <= 1'b1;
      rd_waddr_q <= wb.i_p0_waddr;
      rd_wdata_q <= wb.i_p0_wdata;
    end else begin
      rd_wen_q   <= 1'b0;
    end
  end

  assign wb.o_rd_wen     = rd_wen_q;
  assign wb.o_rd_waddr   = rd_waddr_q;
  assign wb.o_rd_wdata   = rd_wdata_q;
  assign wb.o_p1_starved = starved;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rf_wb_arb;

  localparam int SM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rf_wb_arb_if wb ();

  rf_wb_arb #(.STARVE_MAX(SM)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (wb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int          m_cnt;
  int          m_fav;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    wb.i_p0_valid = v0; wb.i_p0_waddr = a0; wb.i_p0_wdata = d0;
    wb.i_p1_valid = v1; wb.i_p1_waddr = a1; wb.i_p1_wdata = d1;
  endtask

  // One clock cycle: sample at the falling edge, compare against the
  // model, advance the model, then return just after the next rising edge.
  task automatic step(output logic r0, output logic r1, output logic st,
                      output logic wen, output logic [4:0] wa, output logic [31:0] wd);
    logic c0, c1, p1win, g0, exp_st;
    @(negedge clk);
    r0 = wb.o_p0_ready; r1 = wb.o_p1_ready; st = wb.o_p1_starved;
    wen = wb.o_rd_wen; wa = wb.o_rd_waddr; wd = wb.o_rd_wdata;
    if (rst) begin
      m_cnt = 0; m_fav = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      chk("rst_p0_ready", {31'd0, r0}, 32'd0);
      chk("rst_p1_ready", {31'd0, r1}, 32'd0);
      chk("rst_wen",      {31'd0, wen}, 32'd0);
      chk("rst_waddr",    {27'd0, wa}, 32'd0);
      chk("rst_wdata",    wd, 32'd0);
    end else begin
      c0 = wb.i_p0_valid && (wb.i_p0_waddr != 5'd0);
      c1 = wb.i_p1_valid && (wb.i_p1_waddr != 5'd0);
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
      exp_st = 1'b0;
      p1win  = c1 && (!c0 || (m_fav == 1));
`else
      exp_st = (SM != 0) && (m_cnt == SM);
      p1win  = c1 && (!c0 || exp_st);
`endif
      g0 = c0 && !p1win;
      chk("p0_ready", {31'd0, r0}, {31'd0, wb.i_p0_valid && ((wb.i_p0_waddr == 5'd0) || g0)});
      chk("p1_ready", {31'd0, r1}, {31'd0, wb.i_p1_valid && ((wb.i_p1_waddr == 5'd0) || p1win)});
      chk("starved",  {31'd0, st}, {31'd0, exp_st});
      chk("rd_wen",   {31'd0, wen}, {31'd0, m_wen});
      chk("rd_waddr", {27'd0, wa}, {27'd0, m_waddr});
      chk("rd_wdata", wd, m_wdata);
      if (p1win) begin
        m_wen = 1'b1; m_waddr = wb.i_p1_waddr; m_wdata = wb.i_p1_wdata; m_fav = 0;
      end else if (g0) begin
        m_wen = 1'b1; m_waddr = wb.i_p0_waddr; m_wdata = wb.i_p0_wdata; m_fav = 1;
      end else begin
        m_wen = 1'b0;
      end
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
      m_cnt = 0;
`else
      if (p1win || !wb.i_p1_valid) m_cnt = 0;
      else if (c1 && m_cnt < SM)   m_cnt = m_cnt + 1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r0, r1, st, wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        v0, v1, p1exp;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    // Reset with an x0 request present: readys must stay low.
    drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
    step(r0, r1, st, wen, wa, wd);
    step(r0, r1, st, wen, wa, wd);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    chk("idle_wen", {31'd0, wen}, 32'd0);

    // Port 0 alone.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    chk("p0_alone_ready", {31'd0, r0}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    chk("p0_alone_wen",   {31'd0, wen}, 32'd1);
    chk("p0_alone_waddr", {27'd0, wa}, 32'd5);
    chk("p0_alone_wdata", wd, 32'hDEADBEEF);

    // x0 on port 0 alongside a real port-1 write.
    drive(1'b1, 5'd0, 32'hAAAA5555, 1'b1, 5'd7, 32'h12345678);
    step(r0, r1, st, wen, wa, wd);
    chk("x0_p0_ready", {31'd0, r0}, 32'd1);
    chk("x0_p1_ready", {31'd0, r1}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    chk("x0_wen",   {31'd0, wen}, 32'd1);
    chk("x0_waddr", {27'd0, wa}, 32'd7);
    chk("x0_wdata", wd, 32'h12345678);
    step(r0, r1, st, wen, wa, wd);
    chk("x0_no_second_write", {31'd0, wen}, 32'd0);

    // Continuous contention, x3 vs x4.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 6; i++) begin
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
      p1exp = (i % 2) == 1;
`else
      p1exp = (i % 3) == 2;
`endif
      step(r0, r1, st, wen, wa, wd);
      chk("cont_p0_ready", {31'd0, r0}, {31'd0, !p1exp});
      chk("cont_p1_ready", {31'd0, r1}, {31'd0, p1exp});
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
      chk("cont_starved", {31'd0, st}, 32'd0);
`else
      chk("cont_starved", {31'd0, st}, {31'd0, p1exp});
`endif
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    chk("cont_last_waddr", {27'd0, wa}, 32'd4);

    // Asynchronous reset while a grant is pending.
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    drive(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("pre_rst_wen", {31'd0, wb.o_rd_wen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wen",   {31'd0, wb.o_rd_wen}, 32'd0);
    chk("async_rst_ready", {31'd0, wb.o_p0_ready}, 32'd0);
    step(r0, r1, st, wen, wa, wd);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(r0, r1, st, wen, wa, wd);
    chk("post_rst_wen", {31'd0, wen}, 32'd0);
    step(r0, r1, st, wen, wa, wd);
    chk("post_rst_wen2", {31'd0, wen}, 32'd0);

    // Randomized traffic; requesters hold their request until accepted.
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!v0 || r0) begin
        v0 = $urandom_range(0, 3) != 0;
        a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d0 = $urandom;
      end
      if (!v1 || r1) begin
        v1 = $urandom_range(0, 3) != 0;
        a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d1 = $urandom;
      end
      drive(v0, a0, d0, v1, a1, d1);
      step(r0, r1, st, wen, wa, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Shares the single synchronous register-file write port between two writeback requesters: port 0 (ALU/CSR writeback) and port 1 (load-return writeback).
- Arbitrates with valid/ready handshakes, drops x0 writes locally, and registers the winning write.
- Drives the register file write port (wen/waddr/wdata) one cycle after grant.
- Sits between the execute/memory stages and the register file in the multi-cycle and pipelined cores.

Parameters:
- STARVE_MAX, 4: consecutive losses by port 1 before port 1 is forced to win. 0 disables the forcing. Ignored when round-robin is compiled in.

Ports:
- i_clk  input  1  global clock
- i_rst  input  1  asynchronous active-high reset
- i_p0_valid  input  1  port 0 write request
- o_p0_ready  output  1  port 0 request accepted this cycle
- i_p0_waddr  input  5  port 0 destination register
- i_p0_wdata  input  32  port 0 write data
- i_p1_valid  input  1  port 1 write request
- o_p1_ready  output  1  port 1 request accepted this cycle
- i_p1_waddr  input  5  port 1 destination register
- i_p1_wdata  input  32  port 1 write data
- o_rd_wen  output  1  register-file write enable (registered)
- o_rd_waddr  output  5  register-file write address (registered)
- o_rd_wdata  output  32  register-file write data (registered)
- o_p1_starved  output  1  high while port 1 holds forced priority

Behaviour:
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. A requester holds valid, waddr and wdata stable until ready. valid must not depend on ready. ready is combinational from the valids, addresses and arbiter state.
- x0 requests (waddr==0): ready=1 in the same cycle whenever valid. Such a request never consumes the grant and never asserts o_rd_wen.
- Non-x0 requests: at most one is granted per cycle, and the granted port sees ready=1.
- Grant rule (default, fixed priority): port 0 wins when both ports are valid and non-x0. The exception is when the starvation count equals STARVE_MAX and STARVE_MAX is nonzero; then port 1 wins.
- Starvation counter, width clog2(STARVE_MAX+1):
  - increments (saturating) when port 1 is valid, non-x0 and loses;
  - clears when port 1 is granted or port 1 is not valid.
- o_p1_starved = (count == STARVE_MAX) and STARVE_MAX != 0.
- Output stage, on each clock edge:
  - if a grant occurred: o_rd_wen<=1, and o_rd_waddr/o_rd_wdata take the winner's values;
  - otherwise: o_rd_wen<=0, and addr/data hold their previous values.
- Latency is 1 cycle from accepted handshake to o_rd_wen. The register file always accepts, so throughput is one write per cycle with no back-pressure from the output.
- Same-rd collision: no merging. The loser writes on a later cycle and the last write wins. Program ordering between the ports is the requesters' responsibility.
- Reset (asynchronous, active-high):
  - o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0;
  - starvation count=0, round-robin pointer=port 0;
  - o_p0_ready and o_p1_ready are forced to 0 while i_rst is high.
- Reset mid-transfer: a grant in the cycle reset asserts is discarded and o_rd_wen clears immediately. Requesters re-present after reset.

Optional Feature:
- RF_WB_ARB_ROUND_ROBIN_EN defined:
  - the grant alternates by a 1-bit last-winner pointer; on contention the port that did not win most recently wins;
  - the pointer updates only on a non-x0 grant;
  - the starvation counter is held at 0 and o_p1_starved is tied to 0.
- RF_WB_ARB_ROUND_ROBIN_EN undefined: fixed priority with starvation forcing, as described in Behaviour.

Decomposition:
- Package rf_wb_pkg:
  - XLEN=32, REG_ADDR_W=5, REG_X0=5'd0;
  - port index constants WB_PORT_ALU=0 and WB_PORT_LOAD=1.
- One sub-module, rf_wb_arb_pick:
  - purely combinational;
  - takes the valids, the x0 flags and the priority select (starved or pointer);
  - returns the one-hot grant.
- Counter, pointer and output register stay in rf_wb_arb.

Test Plan:
- Reset then idle → o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, both readys 0 while i_rst=1.
- Port 0 alone, waddr=5, wdata=0xDEADBEEF → o_p0_ready=1 in the same cycle; next cycle o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=0xDEADBEEF.
- Both ports valid every cycle, x3 and x4, STARVE_MAX=2, fixed priority → grants p0, p0, p1 (o_p1_starved=1 that cycle), p0, p0, p1.
- Port 0 waddr=0 and port 1 waddr=7 in the same cycle → both readys=1; next cycle o_rd_wen=1 with addr 7; no x0 write ever appears.
- RF_WB_ARB_ROUND_ROBIN_EN defined, both ports continuously valid → grants alternate p0, p1, p0, p1; o_p1_starved stays 0.
- Assert i_rst asynchronously mid-cycle while a grant is pending → o_rd_wen drops immediately and no write appears after reset deasserts.
